// File: rtl/usb_dev_responder.sv
// Device-side USB responder: answers OUT/IN tokens addressed to dev_addr using a one-entry endpoint buffer.
// Define USB_DEV_NAK_EN to NACK IN tokens while the buffer is empty; otherwise those tokens are ignored.
module usb_dev_responder #(
  parameter int DATA_TIMEOUT = 20,
  parameter int MAX_RETRY    = 8,
  parameter int TIMER_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  dev_addr,
  input  logic        pkt_valid,
  input  logic [3:0]  pid_in,
  input  logic [6:0]  addr_in,
  input  logic [3:0]  endp_in,
  input  logic [63:0] data_in,
  input  logic        corrupted,
  input  logic        down_ready,
  output logic        pktready,
  output logic [3:0]  pid_out,
  output logic [63:0] data_out,
  output logic        wr_valid,
  output logic [63:0] wr_data,
  output logic [3:0]  wr_endp,
  input  logic        rd_avail,
  input  logic [63:0] rd_data,
  output logic        rd_ack,
  output logic        busy,
  output logic        xfer_err
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NACK  = 4'b1010;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(DATA_TIMEOUT);
  localparam logic [RW-1:0]      RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, W_DATA, SEND_HS, SEND_DATA, W_HS} state_t;

  state_t             state_q, ret_q;
  logic [TIMER_W-1:0] timer_q;
  logic [RW-1:0]      retry_q;
  logic [3:0]         endp_q;
  logic [63:0]        data_q;
  logic [3:0]         hs_q;

  logic         tok_ok, timer_exp, retry_last, is_data0;
  logic         data_good, data_bad, hs_good, hs_fail;
  logic [RW-1:0] retry_d;

  // Decision-cycle strobes are combinational so they coincide with the decoder strobe.
  always_comb begin
    tok_ok     = pkt_valid && !corrupted && (addr_in == dev_addr);
    timer_exp  = (timer_q == TIMER_MAX);
    retry_d    = retry_q + RW'(1);
    retry_last = (retry_d == RETRY_MAX);
    is_data0   = pkt_valid && (pid_in == PID_DATA0);
    data_good  = (state_q == W_DATA) && is_data0 && !corrupted;
    data_bad   = (state_q == W_DATA) && is_data0 && corrupted;
    hs_good    = (state_q == W_HS) && pkt_valid && !corrupted && (pid_in == PID_ACK);
    hs_fail    = (state_q == W_HS) &&
                 ((pkt_valid && (corrupted || pid_in == PID_NACK)) || (!pkt_valid && timer_exp));

    wr_valid = !rst && data_good;
    wr_data  = wr_valid ? data_in : 64'd0;
    wr_endp  = wr_valid ? endp_q : 4'd0;
    rd_ack   = !rst && hs_good;
    xfer_err = !rst && ((data_bad && retry_last) ||
                        ((state_q == W_DATA) && !pkt_valid && timer_exp) ||
                        (hs_fail && retry_last));
    busy     = !rst && (state_q != IDLE);
    pktready = !rst && ((state_q == SEND_HS) || (state_q == SEND_DATA));
    pid_out  = 4'd0;
    data_out = 64'd0;
    if (!rst && state_q == SEND_HS) begin
      pid_out = hs_q;
    end else if (!rst && state_q == SEND_DATA) begin
      pid_out  = PID_DATA0;
      data_out = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      timer_q <= '0;
      retry_q <= '0;
      endp_q  <= '0;
      data_q  <= '0;
      hs_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tok_ok && pid_in == PID_OUT) begin
            endp_q  <= endp_in;
            timer_q <= '0;
            retry_q <= '0;
            state_q <= W_DATA;
          end else if (tok_ok && pid_in == PID_IN) begin
            if (rd_avail) begin
              data_q  <= rd_data;
              endp_q  <= endp_in;
              retry_q <= '0;
              state_q <= SEND_DATA;
            end else begin
`ifdef USB_DEV_NAK_EN
              hs_q    <= PID_NACK;
              ret_q   <= IDLE;
              state_q <= SEND_HS;
`else
              state_q <= IDLE;
`endif
            end
          end
        end
        W_DATA: begin
          if (data_good) begin
            hs_q    <= PID_ACK;
            ret_q   <= IDLE;
            state_q <= SEND_HS;
          end else if (data_bad) begin
            retry_q <= retry_d;
            if (retry_last) begin
              state_q <= IDLE;
            end else begin
              hs_q    <= PID_NACK;
              ret_q   <= W_DATA;
              timer_q <= '0;
              state_q <= SEND_HS;
            end
          end else if (pkt_valid) begin
            state_q <= IDLE;
          end else if (timer_exp) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        SEND_HS: begin
          if (down_ready) state_q <= ret_q;
        end
        SEND_DATA: begin
          if (down_ready) begin
            timer_q <= '0;
            state_q <= W_HS;
          end
        end
        W_HS: begin
          // Clean non-ACK/NACK packets are ignored; only silence advances the timer.
          if (hs_good) begin
            state_q <= IDLE;
          end else if (hs_fail) begin
            retry_q <= retry_d;
            state_q <= retry_last ? IDLE : SEND_DATA;
          end else if (!pkt_valid) begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_dev_responder.sv
// Scoreboard bench for usb_dev_responder: directed host transactions, expected events queued, monitor compares.
module tb_usb_dev_responder;

  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_DATA0 = 4'b0011,
                         P_ACK = 4'b0010, P_NACK = 4'b1010;
  localparam int TMO = 20;
  localparam logic [1:0] K_WR = 2'd0, K_PKT = 2'd1, K_RDACK = 2'd2, K_ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] a;
    logic [3:0]  b;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  dev_addr = 7'h07;
  logic        pkt_valid = 1'b0;
  logic [3:0]  pid_in = 4'd0;
  logic [6:0]  addr_in = 7'd0;
  logic [3:0]  endp_in = 4'd0;
  logic [63:0] data_in = 64'd0;
  logic        corrupted = 1'b0;
  logic        down_ready = 1'b1;
  logic        pktready;
  logic [3:0]  pid_out;
  logic [63:0] data_out;
  logic        wr_valid;
  logic [63:0] wr_data;
  logic [3:0]  wr_endp;
  logic        rd_avail = 1'b0;
  logic [63:0] rd_data = 64'd0;
  logic        rd_ack;
  logic        busy;
  logic        xfer_err;

  int  checks = 0;
  int  failures = 0;
  ev_t exp_q[$];

  usb_dev_responder dut (
    .clk(clk), .rst(rst), .dev_addr(dev_addr), .pkt_valid(pkt_valid), .pid_in(pid_in),
    .addr_in(addr_in), .endp_in(endp_in), .data_in(data_in), .corrupted(corrupted),
    .down_ready(down_ready), .pktready(pktready), .pid_out(pid_out), .data_out(data_out),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_endp(wr_endp), .rd_avail(rd_avail),
    .rd_data(rd_data), .rd_ack(rd_ack), .busy(busy), .xfer_err(xfer_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [63:0] a, input logic [3:0] b);
    exp_q.push_back('{kind: k, a: a, b: b});
  endtask

  task automatic mon_compare(input ev_t act);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual kind=%0d a=%h b=%h required=none", act.kind, act.a, act.b);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        failures++;
        $display("FAIL event actual kind=%0d a=%h b=%h required kind=%0d a=%h b=%h",
                 act.kind, act.a, act.b, e.kind, e.a, e.b);
      end else begin
        $display("event kind=%0d a=%h b=%h ok", act.kind, act.a, act.b);
      end
    end
  endtask

  // Monitor: every DUT-side event is checked against the scoreboard queue.
  always @(negedge clk) begin
    if (wr_valid) mon_compare('{kind: K_WR, a: wr_data, b: wr_endp});
    if (pktready && down_ready) mon_compare('{kind: K_PKT, a: data_out, b: pid_out});
    if (rd_ack) mon_compare('{kind: K_RDACK, a: 64'd0, b: 4'd0});
    if (xfer_err) mon_compare('{kind: K_ERR, a: 64'd0, b: 4'd0});
  end

  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                          input logic [63:0] data, input logic corr);
    pid_in = pid; addr_in = addr; endp_in = endp; data_in = data; corrupted = corr;
    pkt_valid = 1'b1;
    @(posedge clk); #1;
    pkt_valid = 1'b0; corrupted = 1'b0;
  endtask

  task automatic wait_accept(input string name);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (pktready && down_ready) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_accept required=accept", name);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, pktready, wr_valid, rd_ack, xfer_err, pid_out}, '0);
    chk("reset_data_out", data_out, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;

    // OUT path
    send_pkt(P_OUT, 7'h07, 4'd3, 64'd0, 1'b0);
    chk("out_busy", busy, 1);
    push(K_WR, 64'haabbccdd, 4'd3);
    push(K_PKT, 64'd0, P_ACK);
    send_pkt(P_DATA0, 7'h00, 4'd0, 64'haabbccdd, 1'b0);
    wait_accept("out_ack");
    chk("out_idle", busy, 0);

    // OUT retry: 7 NACKs then abandon
    send_pkt(P_OUT, 7'h07, 4'd1, 64'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        push(K_PKT, 64'd0, P_NACK);
        send_pkt(P_DATA0, 7'h00, 4'd0, 64'h1111, 1'b1);
        wait_accept("out_nack");
      end else begin
        push(K_ERR, 64'd0, 4'd0);
        send_pkt(P_DATA0, 7'h00, 4'd0, 64'h1111, 1'b1);
      end
    end
    chk("retry_idle", busy, 0);

    // IN path: NACK once, then ACK
    rd_avail = 1'b1; rd_data = 64'h1234;
    push(K_PKT, 64'h1234, P_DATA0);
    send_pkt(P_IN, 7'h07, 4'd2, 64'd0, 1'b0);
    rd_data = 64'hdead;
    wait_accept("in_data1");
    push(K_PKT, 64'h1234, P_DATA0);
    send_pkt(P_NACK, 7'h00, 4'd0, 64'd0, 1'b0);
    wait_accept("in_data2");
    push(K_RDACK, 64'd0, 4'd0);
    send_pkt(P_ACK, 7'h00, 4'd0, 64'd0, 1'b0);
    chk("in_idle", busy, 0);

    // Backpressure during SEND_DATA
    rd_data = 64'h5566778899aabbcc; down_ready = 1'b0;
    send_pkt(P_IN, 7'h07, 4'd4, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stable", {pktready, pid_out, data_out}, {1'b1, P_DATA0, 64'h5566778899aabbcc});
    end
    @(posedge clk); #1;
    down_ready = 1'b1;
    push(K_PKT, 64'h5566778899aabbcc, P_DATA0);
    wait_accept("bp_accept");
    push(K_RDACK, 64'd0, 4'd0);
    send_pkt(P_ACK, 7'h00, 4'd0, 64'd0, 1'b0);

    // Filtering: wrong address, corrupted token
    send_pkt(P_OUT, 7'h08, 4'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("filter_addr", busy, 0);
    @(posedge clk); #1;
    send_pkt(P_IN, 7'h07, 4'd0, 64'd0, 1'b1);
    @(negedge clk);
    chk("filter_crc", {busy, pktready}, 0);
    @(posedge clk); #1;

    // OUT then silence: xfer_err exactly TMO cycles after entering W_DATA
    send_pkt(P_OUT, 7'h07, 4'd0, 64'd0, 1'b0);
    push(K_ERR, 64'd0, 4'd0);
    begin
      int cyc = -1;
      for (int i = 0; i < 100 && cyc < 0; i++) begin
        @(negedge clk);
        if (xfer_err) cyc = i;
      end
      chk("timeout_cycle", 64'(cyc), 64'(TMO));
    end
    @(posedge clk); #1;
    chk("timeout_idle", busy, 0);

    // Reset while waiting for the handshake, ACK on the same cycle must be swallowed
    push(K_PKT, 64'h5566778899aabbcc, P_DATA0);
    send_pkt(P_IN, 7'h07, 4'd5, 64'd0, 1'b0);
    wait_accept("rst_data");
    chk("rst_in_whs", busy, 1);
    rst = 1'b1; pid_in = P_ACK; pkt_valid = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {busy, pktready, wr_valid, rd_ack, xfer_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0; pkt_valid = 1'b0;
    @(negedge clk);
    chk("rst_idle", {busy, pktready, rd_ack}, 0);
    @(posedge clk); #1;

    // IN with empty buffer
    rd_avail = 1'b0;
`ifdef USB_DEV_NAK_EN
    push(K_PKT, 64'd0, P_NACK);
    send_pkt(P_IN, 7'h07, 4'd2, 64'd0, 1'b0);
    wait_accept("nak");
    chk("nak_idle", busy, 0);
`else
    send_pkt(P_IN, 7'h07, 4'd2, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("empty_in_silent", {busy, pktready}, 0);
    end
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
